// File: rtl/keypad_pkg.sv
// Shared types, key map and letter-set tables for the multi-tap keypad.
package keypad_pkg;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_END} state_e;

    typedef enum logic [3:0] {
        K_NONE, K_ABC, K_DEF, K_GHI, K_JKL, K_MNO, K_PQRS, K_TUV, K_WXYZ,
        K_BS, K_CLR, K_SUB, K_END, K_SPC
    } key_e;

    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Indexed by letter group (K_ABC = group 0): first letter and set size.
    localparam logic [7:0][7:0] LSET_BASE = {8'h57, 8'h54, 8'h50, 8'h4D, 8'h4A, 8'h47, 8'h44, 8'h41};
    localparam logic [7:0][2:0] LSET_SIZE = {3'd4, 3'd3, 3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};

    // Only codes with exactly one row and one column bit map to a key.
    function automatic key_e kp_decode(input logic [7:0] code);
        case (code)
            8'b1000_0100: return K_ABC;
            8'b1000_0010: return K_DEF;
            8'b1000_0001: return K_BS;
            8'b0100_1000: return K_GHI;
            8'b0100_0100: return K_JKL;
            8'b0100_0010: return K_MNO;
            8'b0100_0001: return K_CLR;
            8'b0010_1000: return K_PQRS;
            8'b0010_0100: return K_TUV;
            8'b0010_0010: return K_WXYZ;
            8'b0010_0001: return K_SUB;
            8'b0001_1000: return K_END;
            8'b0001_0100: return K_SPC;
            default:      return K_NONE;
        endcase
    endfunction

    function automatic logic is_letter(input key_e k);
        return (k >= K_ABC) && (k <= K_WXYZ);
    endfunction

    function automatic logic [2:0] key_grp(input key_e k);
        logic [3:0] t;
        t = k - K_ABC;
        return t[2:0];
    endfunction

endpackage

// File: rtl/keypad_multitap_char_fifo.sv
// Circular character buffer with push, pop, unpush (drop newest) and flush.
module char_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    input  logic       unpush_i,
    input  logic       flush_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_q, wr_q, rd_d, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop, do_unpush;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CW'(DEPTH));
    assign data_o    = mem[rd_q];
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign drop_o    = push_i && !do_push;
    // A pop of the last entry wins over removing it from the tail.
    assign do_unpush = unpush_i && !push_i && (cnt_q > {{AW{1'b0}}, do_pop});

    always_comb begin
        rd_d  = rd_q + AW'(do_pop);
        wr_d  = wr_q + AW'(do_push) - AW'(do_unpush);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop) - CW'(do_unpush);
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem[wr_q] <= data_i;
    end

endmodule

// File: rtl/keypad_multitap.sv
// Multi-tap phone keypad: composes letters from repeated taps and commits
// them into a character buffer, with edit, submit and game-end keys.
module keypad_multitap
    import keypad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100,
    parameter int DEPTH          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  logic [7:0] cur_key,
    output logic [7:0] letter,
    output logic       pending,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       ready,
    output logic       overflow,
    output logic       game_end
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [2:0]    grp_q, grp_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    letter_q, letter_d;
    logic          pending_q, spc_q, spc_d, sub_q, sub_d;
    logic          ready_q, overflow_q, end_q, end_d;

    key_e       key;
    logic       in_pend, push, unpush, flush, drop, full, empty;
    logic [7:0] push_data;

    always_comb begin
        key       = strobe ? kp_decode(cur_key) : K_NONE;
        in_pend   = (state_q == S_PEND);
        state_d   = state_q;
        grp_d     = grp_q;
        idx_d     = idx_q;
        tmr_d     = '0;
        spc_d     = 1'b0;
        sub_d     = 1'b0;
        end_d     = end_q;
        unpush    = 1'b0;
        flush     = 1'b0;
        // A space deferred behind a letter commit goes out this cycle.
        push      = spc_q;
        push_data = spc_q ? ASCII_SPACE : letter_q;
        if (state_q != S_END) begin
            if (is_letter(key)) begin
                if (in_pend && key_grp(key) == grp_q) begin
                    idx_d = ({1'b0, idx_q} == LSET_SIZE[grp_q] - 3'd1) ? 2'd0 : idx_q + 2'd1;
                end else begin
                    if (in_pend) begin
                        push      = 1'b1;
                        push_data = letter_q;
                    end
                    grp_d   = key_grp(key);
                    idx_d   = 2'd0;
                    state_d = S_PEND;
                end
            end else begin
                case (key)
                    K_SPC: begin
                        state_d = S_IDLE;
                        if (in_pend) begin
                            push      = 1'b1;
                            push_data = letter_q;
                            spc_d     = 1'b1;
                        end else if (spc_q) begin
                            spc_d = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_data = ASCII_SPACE;
                        end
                    end
                    K_SUB: begin
                        state_d = S_IDLE;
                        sub_d   = 1'b1;
                        if (in_pend) begin
                            push      = 1'b1;
                            push_data = letter_q;
                        end
                    end
                    K_BS: begin
                        state_d = S_IDLE;
                        // Cancelling a not-yet-pushed space is the same as removing it.
                        if (!in_pend) begin
                            if (spc_q) push = 1'b0;
                            else       unpush = 1'b1;
                        end
                    end
                    K_CLR: begin
                        state_d = S_IDLE;
                        push    = 1'b0;
                        flush   = 1'b1;
                    end
                    K_END: begin
                        state_d = S_END;
                        push    = 1'b0;
                        flush   = 1'b1;
                        end_d   = 1'b1;
                    end
                    default: begin
                        if (in_pend) begin
                            if (tmr_q == TMR_MAX) begin
                                push      = 1'b1;
                                push_data = letter_q;
                                state_d   = S_IDLE;
                            end else begin
                                tmr_d = tmr_q + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
        letter_d = (state_d == S_PEND) ? LSET_BASE[grp_d] + {6'd0, idx_d} : ASCII_NUL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grp_q      <= '0;
            idx_q      <= '0;
            tmr_q      <= '0;
            letter_q   <= ASCII_NUL;
            pending_q  <= 1'b0;
            spc_q      <= 1'b0;
            sub_q      <= 1'b0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            idx_q      <= idx_d;
            tmr_q      <= tmr_d;
            letter_q   <= letter_d;
            pending_q  <= (state_d == S_PEND);
            spc_q      <= spc_d;
            sub_q      <= sub_d;
            ready_q    <= sub_q;
            overflow_q <= drop;
            end_q      <= end_d;
        end
    end

    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .data_i   (push_data),
        .pop_i    (char_ready),
        .unpush_i (unpush),
        .flush_i  (flush),
        .data_o   (char_data),
        .full_o   (full),
        .empty_o  (empty),
        .drop_o   (drop)
    );

    assign letter     = letter_q;
    assign pending    = pending_q;
    assign char_valid = !empty;
    assign ready      = ready_q;
    assign overflow   = overflow_q;
    assign game_end   = end_q;

endmodule

// File: tb/tb_keypad_multitap.sv
// Directed bench for keypad_multitap: per-cycle vector table plus
// hand-written sequences for buffer, edit, game-end and reset corners.
module tb_keypad_multitap;
    logic       clk = 1'b0, rst = 1'b1, strobe = 1'b0, char_ready = 1'b0;
    logic [7:0] cur_key = 8'h00;
    logic [7:0] letter, char_data;
    logic       pending, char_valid, ready, overflow, game_end;

    int nvec = 0, nerr = 0;

    keypad_multitap #(.TIMEOUT_CYCLES(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .cur_key(cur_key),
        .letter(letter), .pending(pending), .char_data(char_data),
        .char_valid(char_valid), .char_ready(char_ready), .ready(ready),
        .overflow(overflow), .game_end(game_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stb;
        logic [7:0] key;
        logic       rdy;
        logic [7:0] letter;
        logic       pend;
        logic       valid;
        logic [7:0] data;
        logic       ovf;
        logic       rdyo;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic stb, input logic [7:0] key, input logic rdy,
                       input logic [7:0] l, input logic p, input logic v,
                       input logic [7:0] d, input logic o, input logic r);
        vec_t x;
        x = '{stb, key, rdy, l, p, v, d, o, r};
        tv.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [7:0] k);
        strobe  = 1'b1;
        cur_key = k;
        tick();
        strobe  = 1'b0;
        cur_key = 8'h00;
    endtask

    // Tap a letter key n times, then submit to push it.
    task automatic commit(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) tap(k);
        tap(8'h21);
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        chk({nm, " valid"}, {7'd0, char_valid}, 8'd1);
        chk({nm, " data"}, char_data, exp);
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " letter"},   letter, 8'd0);
        chk({nm, " pending"},  {7'd0, pending}, 8'd0);
        chk({nm, " valid"},    {7'd0, char_valid}, 8'd0);
        chk({nm, " ready"},    {7'd0, ready}, 8'd0);
        chk({nm, " overflow"}, {7'd0, overflow}, 8'd0);
        chk({nm, " game_end"}, {7'd0, game_end}, 8'd0);
    endtask

    initial begin
        // R0C2 taps two cycles apart, then timeout commit of 'D'
        add(1, 8'h82, 0, 68, 1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 68, 1, 0, 0, 0, 0);
        add(1, 8'h82, 0, 69, 1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 69, 1, 0, 0, 0, 0);
        add(1, 8'h82, 0, 70, 1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 70, 1, 0, 0, 0, 0);
        add(1, 8'h82, 0, 68, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 8'h00, 0, 68, 1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 1, 68, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        // PQRS wrap, then a different key commits 'P'
        add(1, 8'h28, 0, 80, 1, 0, 0, 0, 0);
        add(1, 8'h28, 0, 81, 1, 0, 0, 0, 0);
        add(1, 8'h28, 0, 82, 1, 0, 0, 0, 0);
        add(1, 8'h28, 0, 83, 1, 0, 0, 0, 0);
        add(1, 8'h28, 0, 80, 1, 0, 0, 0, 0);
        add(1, 8'h48, 0, 71, 1, 1, 80, 0, 0);
        add(0, 8'h00, 1, 71, 1, 0, 0, 0, 0);
        add(1, 8'h41, 0, 0, 0, 0, 0, 0, 0);
        // invalid codes in IDLE and PEND, then submit
        add(1, 8'hC4, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h80, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h11, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h84, 0, 65, 1, 0, 0, 0, 0);
        add(1, 8'hC4, 0, 65, 1, 0, 0, 0, 0);
        add(1, 8'h11, 0, 65, 1, 0, 0, 0, 0);
        add(1, 8'h21, 0, 0, 0, 1, 65, 0, 0);
        add(0, 8'h00, 0, 0, 0, 1, 65, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 65, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        // space from PEND: letter then 8'h20 on the next cycle
        add(1, 8'h84, 0, 65, 1, 0, 0, 0, 0);
        add(1, 8'h14, 0, 0, 0, 1, 65, 0, 0);
        add(0, 8'h00, 1, 0, 0, 1, 8'h20, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);

        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (tv[i]) begin
            strobe     = tv[i].stb;
            cur_key    = tv[i].key;
            char_ready = tv[i].rdy;
            tick();
            chk($sformatf("v%0d letter", i), letter, tv[i].letter);
            chk($sformatf("v%0d pending", i), {7'd0, pending}, {7'd0, tv[i].pend});
            chk($sformatf("v%0d valid", i), {7'd0, char_valid}, {7'd0, tv[i].valid});
            if (tv[i].valid) chk($sformatf("v%0d data", i), char_data, tv[i].data);
            chk($sformatf("v%0d overflow", i), {7'd0, overflow}, {7'd0, tv[i].ovf});
            chk($sformatf("v%0d ready", i), {7'd0, ready}, {7'd0, tv[i].rdyo});
        end
        strobe = 1'b0; cur_key = 8'h00; char_ready = 1'b0;

        // full buffer: fifth commit dropped, then accepted alongside a pop
        commit(8'h84, 1); commit(8'h84, 2); commit(8'h84, 3); commit(8'h82, 1);
        tap(8'h82); tap(8'h82); tap(8'h21);
        chk("ovf pulse", {7'd0, overflow}, 8'd1);
        chk("ovf head", char_data, 8'h41);
        tick();
        chk("ovf one cycle", {7'd0, overflow}, 8'd0);
        tap(8'h82); tap(8'h82);
        char_ready = 1'b1;
        tap(8'h21);
        char_ready = 1'b0;
        chk("push+pop no ovf", {7'd0, overflow}, 8'd0);
        pop_expect("drain B", 8'h42);
        pop_expect("drain C", 8'h43);
        pop_expect("drain D", 8'h44);
        pop_expect("drain E", 8'h45);
        chk("drained", {7'd0, char_valid}, 8'd0);

        // backspace and clear
        commit(8'h84, 1); commit(8'h82, 1);
        tap(8'h81);
        chk("bs idle head", char_data, 8'h41);
        tap(8'h84);
        chk("bs pend before", {7'd0, pending}, 8'd1);
        tap(8'h81);
        chk("bs pend pending", {7'd0, pending}, 8'd0);
        chk("bs pend letter", letter, 8'd0);
        pop_expect("bs keep A", 8'h41);
        chk("bs one entry", {7'd0, char_valid}, 8'd0);
        commit(8'h84, 1);
        tap(8'h41);
        chk("clear valid", {7'd0, char_valid}, 8'd0);
        commit(8'h84, 1);
        char_ready = 1'b1;
        tap(8'h81);
        char_ready = 1'b0;
        chk("pop vs bs", {7'd0, char_valid}, 8'd0);
        commit(8'h82, 1);
        pop_expect("after pop vs bs", 8'h44);
        chk("after pop vs bs empty", {7'd0, char_valid}, 8'd0);

        // game end while pending with two entries
        commit(8'h84, 1); commit(8'h82, 1);
        tap(8'h48);
        tap(8'h18);
        chk("end flag", {7'd0, game_end}, 8'd1);
        chk("end flush", {7'd0, char_valid}, 8'd0);
        chk("end pending", {7'd0, pending}, 8'd0);
        tap(8'h84); tap(8'h14); tap(8'h41);
        chk("end ignore letter", letter, 8'd0);
        chk("end ignore valid", {7'd0, char_valid}, 8'd0);
        chk("end sticky", {7'd0, game_end}, 8'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_all_zero("async rst");
        #1 rst = 1'b0;
        tick();

        // reset mid-tap loses the pending letter
        tap(8'h84);
        chk("abort pending", {7'd0, pending}, 8'd1);
        #2 rst = 1'b1;
        #1 chk("abort letter", letter, 8'd0);
        chk("abort pend0", {7'd0, pending}, 8'd0);
        #1 rst = 1'b0;
        repeat (10) tick();
        chk("abort no commit", {7'd0, char_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/keypad_multitap.md
KEYPAD_MULTITAP -- requirements
Module: keypad_multitap

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100: idle cycles after the last tap before the pending letter auto-commits; legal range is 2 or more.
REQ-002 SHALL have parameter DEPTH, default 8: committed-character buffer entries; power of two, 2 or more.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port strobe, input, 1: one-cycle pulse marking cur_key valid.
REQ-006 SHALL have port cur_key, input, 8: {row one-hot [7:4], col one-hot [3:0]}; bit 7 is R0, bit 3 is C0.
REQ-007 SHALL have port letter, output, 8: ASCII of the pending letter; 8'd0 when none is pending.
REQ-008 SHALL have port pending, output, 1: a multi-tap letter is being composed.
REQ-009 SHALL have port char_data, output, 8: ASCII at the buffer head.
REQ-010 SHALL have port char_valid, output, 1: the buffer is non-empty.
REQ-011 SHALL have port char_ready, input, 1: the consumer pops the head when char_valid and char_ready are both high.
REQ-012 SHALL have port ready, output, 1: one-cycle pulse on submit.
REQ-013 SHALL have port overflow, output, 1: one-cycle pulse when a commit is dropped because the buffer is full.
REQ-014 SHALL have port game_end, output, 1: sticky; stays high from the game-end key until reset.

Function
REQ-015 SHALL decode cur_key only when strobe is high and exactly one row bit and exactly one column bit are set; any other code is invalid and SHALL have no effect.
REQ-016 SHALL use this key map:
- R0: C1 = ABC, C2 = DEF, C3 = backspace
- R1: C0 = GHI, C1 = JKL, C2 = MNO, C3 = clear
- R2: C0 = PQRS, C1 = TUV, C2 = WXYZ, C3 = submit
- R3: C0 = game end, C1 = space (8'h20, commits immediately)
- R0C0, R3C2 and R3C3 are invalid.
REQ-017 SHALL have three states: IDLE, PEND and END.
REQ-018 SHALL, in IDLE on a letter key, enter PEND with the first letter of that key's set and index 0.
REQ-019 SHALL, in PEND on the same key, advance the index modulo the set size (3 or 4), so C wraps to A and S wraps to P.
REQ-020 SHALL, in PEND on a different letter key, commit the pending letter and start the new key at index 0, both in the same cycle.
REQ-021 SHALL reload the timeout counter to 0 on every accepted tap; in PEND, when the counter reaches TIMEOUT_CYCLES-1, it SHALL auto-commit the letter and go to IDLE on the next edge.
REQ-022 SHALL handle space this way: commit any pending letter, then push 8'h20; the two pushes happen on consecutive cycles; end state is IDLE.
REQ-023 SHALL handle submit this way: commit any pending letter, pulse ready for exactly 1 cycle on the following edge, end state is IDLE.
REQ-024 SHALL handle backspace this way: in PEND, discard the pending letter with no commit; in IDLE, remove the newest buffer entry, or do nothing when the buffer is empty.
REQ-025 SHALL handle clear this way: discard the pending letter and flush the buffer; end state is IDLE.
REQ-026 SHALL handle game end this way: discard the pending letter, flush the buffer, set game_end and enter END; END SHALL ignore every key until reset.
REQ-027 SHALL make every strobe-driven update visible one cycle after the sampling edge.
REQ-028 SHALL, when the buffer is full, drop the commit, pulse overflow, and still apply the state change.
REQ-029 SHALL allow a push and a pop in the same cycle, including when the buffer is full; in that case no overflow is raised.
REQ-030 SHALL give a pop priority over an IDLE backspace when both fall in the same cycle and the buffer holds one entry; the backspace then has no effect.
REQ-031 SHALL size the timeout counter as $clog2(TIMEOUT_CYCLES) bits, and it SHALL NOT count in IDLE or END.

Reset
REQ-032 SHALL, while rst is high, immediately drive: state IDLE, letter 0, pending 0, char_valid 0, ready 0, overflow 0, game_end 0, buffer empty, timeout counter 0.
REQ-033 SHALL treat reset asserted mid-tap or mid-push as an abort; the pending letter is lost and no commit occurs.

Structure
REQ-034 SHALL take the following from package keypad_pkg: the state enum, the key-code enum, the ASCII constants, the letter-set base and size tables, and the decode function.
REQ-035 SHALL instantiate sub-module char_fifo, a DEPTH-entry circular buffer with push, pop and unpush (tail decrement) and with full and empty flags.

Verification
REQ-036 SHALL run the bench with TIMEOUT_CYCLES=8 and DEPTH=4.
REQ-037 SHALL cover scenario 1: R0C2 tapped 4 times, 2 cycles apart -> letter goes 68, 69, 70, 68; then 8 idle cycles -> 'D' is pushed and pending=0.
REQ-038 SHALL cover scenario 2: R2C0 tapped 5 times -> letter goes P, Q, R, S, P; then R1C0 -> 'P' is committed and letter=71 ('G').
REQ-039 SHALL cover scenario 3: commit A, B, C, D with char_ready=0, then a fifth commit -> overflow pulses 1 cycle and the buffer holds ABCD; then the same commit with char_ready=1 -> no overflow and the sequence BCD plus the new letter results.
REQ-040 SHALL cover scenario 4:
- commit 'A', 'D'
- backspace in IDLE -> buffer holds 'A'
- tap R0C1 then backspace -> pending=0, buffer still holds 'A'
- clear -> char_valid=0.
REQ-041 SHALL cover scenario 5:
- invalid codes 8'b1100_0100, 8'b1000_0000 and R3C3 with strobe -> no output change
- tap R0C1 then submit -> 'A' is pushed, then ready pulses for 1 cycle.
REQ-042 SHALL cover scenario 6: game end while PEND with 2 entries -> game_end=1, buffer empty, later taps ignored; then assert rst asynchronously between edges -> all outputs 0 immediately.
